keycode_fifo_pio: RTL and testbench
===================================

# keycode_fifo_pio

Parametrised successor to the single-register keycode output port. It sits on the Avalon-MM bus as a NIOS II slave and buffers keycodes written by software in a FIFO. The FIFO drains to game logic through a valid/ready stream, so bursts of USB key events are not lost between frames. It also provides status, flush, overflow detection and a drain interrupt.

## Interface
- DATA_WIDTH, 8, keycode width in bits (1..16)
- DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries (1..7)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait states
- irq  out  1  level interrupt to NIOS II
- out_data  out  DATA_WIDTH  FIFO head keycode
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle
- out_port  out  DATA_WIDTH  last keycode consumed; legacy hold output

## Operation
- Write strobe: chipselect & ~write_n. Read strobe: chipselect & ~read_n.
- Register map:
  - addr 0 DATA
    - Write: push writedata[DATA_WIDTH-1:0].
    - Read: out_port zero-extended; no side effect.
  - addr 1 STATUS
    - Read: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 drained (sticky), bits[15:8] count zero-extended, rest 0.
    - Write: 1 in bit2 clears overflow; 1 in bit3 clears drained.
  - addr 2 CONTROL
    - Read: bit0 irq_en, rest 0.
    - Write: bit0 sets irq_en. bit1=1 flushes the FIFO (self-clearing, reads 0).
  - addr 3: reads 0, writes ignored.
- Pop: out_valid & out_ready. The head entry is removed, and out_port loads the popped value on the same edge.
- Push accepted if not full, or if full and a pop occurs in the same cycle. Otherwise the data is dropped and overflow is set.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO: no bypass. out_valid rises the next cycle.
- Flush clears count and pointers and discards any same-cycle push or pop. It does not change out_port, overflow, drained or irq_en, and a dropped push during flush does not set overflow.
- drained sets when a pop takes count from 1 to 0. Flush does not set drained.
- Set and clear of the same sticky bit in the same cycle: set wins.
- irq = irq_en & (drained | overflow), combinational from registers.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is DEPTH_LOG2+1 bits.
- full = (count == 2^DEPTH_LOG2). empty = (count == 0).
- Storage needs no reset. out_data is undefined when out_valid=0; the bench must not check it then.

## Timing
- Reset values: readdata 0, irq 0, out_valid 0, out_port 0, count 0, pointers 0, overflow 0, drained 0, irq_en 0.
- A push on edge N makes out_valid=1 and out_data equal to the pushed value in cycle N+1.
- A pop on edge N updates out_port and the head in cycle N+1.
- STATUS reads reflect state registered at the previous edge.
- A flush on edge N makes out_valid=0 in cycle N+1.
- Reset mid-operation immediately returns all state to reset values, independent of clk.

## Test plan
- Reset, then read STATUS -> 0x00000001. out_valid=0, out_port=0, irq=0.
- Push 0x04, 0x16, 0x07 with out_ready=0, then read STATUS -> count 3, empty 0. Raise out_ready -> out_data 0x04, 0x16, 0x07 on consecutive cycles, out_port=0x07 at the end, drained=1.
- DEPTH_LOG2=3: push 9 values 0x01..0x09 -> full=1, overflow=1 after the ninth push. Drain yields 0x01..0x08, and 0x09 is lost.
- With the FIFO full, push 0x2A in the same cycle as a pop -> push accepted, count stays 8, overflow stays 0, 0x2A is the last value out.
- Set irq_en=1, push 0x05 and pop it -> irq=1. Write STATUS 0x8 -> irq=0. Overflow with irq_en=1 -> irq=1.
- Push 3 values, then write CONTROL 0x2 in the same cycle as an out_ready pop -> count 0 next cycle, out_port unchanged, drained stays 0. Asserting reset mid-stream -> all outputs 0 at once.

Source files
------------

// File: rtl/keycode_fifo_pio.sv
// keycode_fifo_pio: Avalon-MM slave that buffers software keycodes in a FIFO drained by a valid/ready stream
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   address_i, chipselect_i,
//   write_n_i, read_n_i,
//   writedata_i, readdata_o   Avalon-MM slave (DATA, STATUS, CONTROL), zero-wait-state reads
//   irq_o                     level interrupt: irq_en & (drained | overflow)
//   out_data_o, out_valid_o,
//   out_ready_i               FIFO head stream to game logic
//   out_port_o                last keycode consumed
module keycode_fifo_pio #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [1:0]            address_i,
   input  logic                  chipselect_i,
   input  logic                  write_n_i,
   input  logic                  read_n_i,
   input  logic [31:0]           writedata_i,
   output logic [31:0]           readdata_o,
   output logic                  irq_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_port_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] port_q, port_d;
   logic ovf_q, ovf_d, drn_q, drn_d, irq_en_q, irq_en_d;
   logic wr, rd, empty, full, flush, pop, push_req, push, stat_wr, ctrl_wr;
   logic [31:0] status;
   logic unused_wd;
   assign unused_wd = ^writedata_i;
   assign wr       = chipselect_i & ~write_n_i;
   assign rd       = chipselect_i & ~read_n_i;
   assign empty    = count_q == '0;
   assign full     = count_q == (DEPTH_LOG2+1)'(DEPTH);
   assign stat_wr  = wr & (address_i == 2'd1);
   assign ctrl_wr  = wr & (address_i == 2'd2);
   assign flush    = ctrl_wr & writedata_i[1];
   assign push_req = wr & (address_i == 2'd0);
   // flush swallows any same-cycle pop and push
   assign pop      = ~empty & out_ready_i & ~flush;
   assign push     = push_req & ~flush & (~full | pop);
   always_comb begin
      wptr_d   = flush ? '0 : push ? wptr_q + 1'b1 : wptr_q;
      rptr_d   = flush ? '0 : pop ? rptr_q + 1'b1 : rptr_q;
      count_d  = flush ? '0 : (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
      port_d   = pop ? mem_q[rptr_q] : port_q;
      // set terms are ORed after the clear so a same-cycle set wins
      ovf_d    = (ovf_q & ~(stat_wr & writedata_i[2])) | (push_req & ~flush & full & ~pop);
      drn_d    = (drn_q & ~(stat_wr & writedata_i[3])) | (pop & ~push & (count_q == 1));
      irq_en_d = ctrl_wr ? writedata_i[0] : irq_en_q;
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         port_q   <= '0;
         ovf_q    <= 1'b0;
         drn_q    <= 1'b0;
         irq_en_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         port_q   <= port_d;
         ovf_q    <= ovf_d;
         drn_q    <= drn_d;
         irq_en_q <= irq_en_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= writedata_i[DATA_WIDTH-1:0];
   end
   assign status      = {16'b0, 8'(count_q), 4'b0, drn_q, ovf_q, full, empty};
   assign readdata_o  = !rd ? '0 : address_i == 2'd0 ? 32'(port_q) : address_i == 2'd1 ? status :
                        address_i == 2'd2 ? {31'b0, irq_en_q} : '0;
   assign irq_o       = irq_en_q & (drn_q | ovf_q);
   assign out_valid_o = ~empty;
   assign out_data_o  = mem_q[rptr_q];
   assign out_port_o  = port_q;
endmodule

// File: tb/tb_keycode_fifo_pio.sv
// tb_keycode_fifo_pio: vector table plus scoreboard model checking keycode_fifo_pio
module tb_keycode_fifo_pio;
   localparam int DW = 8;
   localparam int DL = 3;
   localparam int DEPTH = 1 << DL;
   logic clk = 1'b0, reset = 1'b1;
   logic [1:0] address = '0;
   logic chipselect = 1'b0, write_n = 1'b1, read_n = 1'b1, out_ready = 1'b0;
   logic [31:0] writedata = '0, readdata;
   logic irq, out_valid;
   logic [DW-1:0] out_data, out_port;
   int checks = 0, errors = 0;
   logic [DW-1:0] mdl [$];
   logic [DW-1:0] m_port = '0;
   logic m_ovf = 1'b0, m_drn = 1'b0, m_irqen = 1'b0;
   typedef struct {
      logic [1:0]  a;
      bit          w;
      bit          r;
      logic [31:0] wd;
      bit          rdy;
      bit          has_exp;
      logic [31:0] exp;
   } vec_t;
   vec_t tv [13];
   keycode_fifo_pio #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
      .clk_i(clk), .reset_i(reset), .address_i(address), .chipselect_i(chipselect),
      .write_n_i(write_n), .read_n_i(read_n), .writedata_i(writedata), .readdata_o(readdata),
      .irq_o(irq), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_port_o(out_port)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] model_read(input logic [1:0] a);
      logic [7:0] n;
      n = 8'(mdl.size());
      return a == 2'd0 ? 32'(m_port) :
             a == 2'd1 ? {16'b0, n, 4'b0, m_drn, m_ovf, n == 8'(DEPTH), n == 8'd0} :
             a == 2'd2 ? {31'b0, m_irqen} : 32'h0;
   endfunction
   task automatic step(input logic [1:0] a, input bit w, input bit r, input logic [31:0] wd,
                       input bit rdy, input bit has_exp, input logic [31:0] exp);
      bit flush, pop, push_req, was_full, was_one, pushed, ovf_set, drn_set;
      @(negedge clk);
      address = a; chipselect = w | r; write_n = ~w; read_n = ~r; writedata = wd; out_ready = rdy;
      #1;
      chk("out_valid", 32'(out_valid), 32'(mdl.size() != 0));
      if (mdl.size() != 0) chk("out_data", 32'(out_data), 32'(mdl[0]));
      chk("out_port", 32'(out_port), 32'(m_port));
      chk("irq", 32'(irq), 32'(m_irqen & (m_ovf | m_drn)));
      if (r) chk("readdata", readdata, model_read(a));
      if (has_exp) chk("vector", readdata, exp);
      flush    = w && a == 2'd2 && wd[1];
      push_req = w && a == 2'd0;
      was_full = mdl.size() == DEPTH;
      was_one  = mdl.size() == 1;
      pop      = mdl.size() != 0 && rdy && !flush;
      pushed   = 1'b0;
      ovf_set  = 1'b0;
      if (flush) mdl.delete();
      else begin
         if (pop) m_port = mdl.pop_front();
         if (push_req) begin
            if (!was_full || pop) begin
               mdl.push_back(wd[DW-1:0]);
               pushed = 1'b1;
            end else ovf_set = 1'b1;
         end
      end
      drn_set = pop && was_one && !pushed;
      if (w && a == 2'd1 && wd[2]) m_ovf = 1'b0;
      if (w && a == 2'd1 && wd[3]) m_drn = 1'b0;
      if (ovf_set) m_ovf = 1'b1;
      if (drn_set) m_drn = 1'b1;
      if (w && a == 2'd2) m_irqen = wd[0];
   endtask
   task automatic idle(input bit rdy);
      step(2'd3, 1'b0, 1'b0, 32'h0, rdy, 1'b0, 32'h0);
   endtask
   task automatic rd_exp(input logic [1:0] a, input logic [31:0] exp);
      step(a, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, exp);
   endtask
   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input bit rdy);
      step(a, 1'b1, 1'b0, d, rdy, 1'b0, 32'h0);
   endtask
   initial begin
      tv[0]  = '{2'd1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0001};
      tv[1]  = '{2'd0, 1'b1, 1'b0, 32'h04, 1'b0, 1'b0, 32'h0};
      tv[2]  = '{2'd0, 1'b1, 1'b0, 32'h16, 1'b0, 1'b0, 32'h0};
      tv[3]  = '{2'd0, 1'b1, 1'b0, 32'h07, 1'b0, 1'b0, 32'h0};
      tv[4]  = '{2'd1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0300};
      tv[5]  = '{2'd3, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0};
      tv[6]  = '{2'd3, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0};
      tv[7]  = '{2'd3, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0};
      tv[8]  = '{2'd1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0009};
      tv[9]  = '{2'd0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0007};
      tv[10] = '{2'd1, 1'b1, 1'b0, 32'h8,  1'b0, 1'b0, 32'h0};
      tv[11] = '{2'd1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0000_0001};
      tv[12] = '{2'd3, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0};
      repeat (2) @(negedge clk);
      #1;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_port", 32'(out_port), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 13; i++) step(tv[i].a, tv[i].w, tv[i].r, tv[i].wd, tv[i].rdy, tv[i].has_exp, tv[i].exp);
      for (int i = 1; i <= 9; i++) wr_reg(2'd0, 32'(i), 1'b0);
      rd_exp(2'd1, 32'h0000_0806);
      for (int i = 0; i < 8; i++) idle(1'b1);
      chk("lost_9th", 32'(m_port), 32'h08);
      rd_exp(2'd1, 32'h0000_000D);
      wr_reg(2'd1, 32'hC, 1'b0);
      rd_exp(2'd1, 32'h0000_0001);
      for (int i = 0; i < 8; i++) wr_reg(2'd0, 32'h10 + 32'(i), 1'b0);
      rd_exp(2'd1, 32'h0000_0802);
      wr_reg(2'd0, 32'h2A, 1'b1);
      rd_exp(2'd1, 32'h0000_0802);
      for (int i = 0; i < 8; i++) idle(1'b1);
      rd_exp(2'd0, 32'h0000_002A);
      wr_reg(2'd1, 32'h8, 1'b0);
      wr_reg(2'd0, 32'hA1, 1'b0);
      wr_reg(2'd0, 32'hA2, 1'b0);
      wr_reg(2'd0, 32'hA3, 1'b0);
      wr_reg(2'd2, 32'h2, 1'b1);
      rd_exp(2'd1, 32'h0000_0001);
      rd_exp(2'd0, 32'h0000_002A);
      wr_reg(2'd2, 32'h1, 1'b0);
      rd_exp(2'd2, 32'h0000_0001);
      wr_reg(2'd0, 32'h05, 1'b0);
      idle(1'b1);
      idle(1'b0);
      chk("irq_drained", 32'(irq), 32'h1);
      wr_reg(2'd1, 32'h8, 1'b0);
      idle(1'b0);
      chk("irq_cleared", 32'(irq), 32'h0);
      for (int i = 0; i < 9; i++) wr_reg(2'd0, 32'h30 + 32'(i), 1'b0);
      idle(1'b0);
      chk("irq_overflow", 32'(irq), 32'h1);
      @(negedge clk);
      address = 2'd3; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; out_ready = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_port", 32'(out_port), 32'h0);
      chk("mid_rst_irq", 32'(irq), 32'h0);
      chk("mid_rst_readdata", readdata, 32'h0);
      mdl.delete();
      m_port = '0; m_ovf = 1'b0; m_drn = 1'b0; m_irqen = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      rd_exp(2'd1, 32'h0000_0001);
      rd_exp(2'd2, 32'h0000_0000);
      idle(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
